aq_djpeg_fetch_ctrl: RTL

Frame-level controller that sequences one JPEG decode per command. It fetches the compressed stream from memory in bursts, buffers it in an internal FIFO, and feeds the decoder's 32-bit input port. It watches decoder idle and output activity to detect completion, timeout or abort. It sits between the system memory read channel and the decoder's DataIn/DataInEnable/DataInRead/DataInReq interface.

---
 rtl/aq_djpeg_fetch_ctrl.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/aq_djpeg_fetch_ctrl.sv
// Frame fetch controller for the JPEG decoder: bursts the compressed stream from
// memory into a show-ahead FIFO and tracks decoder completion, timeout and abort.
module aq_djpeg_fetch_ctrl #(
    parameter int DEPTH   = 32,
    parameter int BURST   = 16,
    parameter int TIMEOUT = 1048576
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        CmdStart,
    input  logic [31:0] CmdAddr,
    input  logic [31:0] CmdLength,
    input  logic        CmdAbort,
    output logic        CmdBusy,
    output logic        CmdDone,
    output logic [1:0]  CmdStatus,
    output logic [31:0] PixelCount,
    output logic        RdReq,
    output logic [31:0] RdAddr,
    output logic [7:0]  RdLen,
    input  logic        RdAck,
    input  logic [31:0] RdData,
    input  logic        RdDataValid,
    output logic [31:0] DataIn,
    output logic        DataInEnable,
    input  logic        DataInRead,
    input  logic        DataInReq,
    input  logic        JpegDecodeIdle,
    input  logic        OutEnable,
    input  logic        OutReady
);

    // state | meaning
    // IDLE  | waiting for CmdStart
    // FETCH | issuing bursts, feeding decoder
    // DRAIN | whole stream fetched, waiting for decoder to finish
    // FLUSH | sinking in-flight beats, clearing the FIFO
    // DONE  | one-cycle CmdDone pulse
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] DRAIN = 3'd2;
    localparam logic [2:0] FLUSH = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0]   fifoDepth   = (AW+1)'(DEPTH);
    localparam logic [TW-1:0] timerReload = TW'(TIMEOUT - 1);

    logic [2:0]    state;
    logic [31:0]   addr;
    logic [31:0]   wordsLeft;
    logic [7:0]    beatsLeft;
    logic          started;
    logic [TW-1:0] timer;

    logic [31:0]   fifoMem [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic [AW:0]   count;

    logic          active;
    logic          fifoEmpty;
    logic          fifoPop;
    logic          fifoWrite;
    logic          fifoClear;
    logic          pixelAccept;
    logic          activity;
    logic          completion;
    logic          timeoutHit;
    logic          abortHit;
    logic          ackNow;
    logic          issue;
    logic [7:0]    lenNext;
    logic [AW:0]   freeWords;

    assign active      = (state == FETCH) || (state == DRAIN);
    assign CmdBusy     = active || (state == FLUSH);
    assign CmdDone     = (state == DONE);
    assign fifoEmpty   = (count == '0);
    assign fifoPop     = DataInRead && !fifoEmpty;
    assign fifoWrite   = active && RdDataValid && (beatsLeft != 8'd0);
    assign pixelAccept = OutEnable && OutReady && CmdBusy;
    assign activity    = fifoPop || fifoWrite || pixelAccept;
    assign completion  = active && started && JpegDecodeIdle;
    assign timeoutHit  = active && !activity && (timer == '0);
    assign abortHit    = active && CmdAbort;
    assign ackNow      = RdReq && RdAck;
    assign lenNext     = (wordsLeft >= 32'(BURST)) ? 8'(BURST) : wordsLeft[7:0];
    assign freeWords   = fifoDepth - count;
    assign fifoClear   = (state == FLUSH) && !ackNow && (beatsLeft == 8'd0);

    // Never launch a burst in the cycle the frame is being torn down.
    assign issue = (state == FETCH) && !RdReq && (beatsLeft == 8'd0) && (wordsLeft != 32'd0)
                   && DataInReq && (32'(freeWords) >= 32'(lenNext))
                   && !(completion || timeoutHit || abortHit);

    assign DataInEnable = !fifoEmpty;
    assign DataIn       = fifoEmpty ? 32'd0 : fifoMem[rdPtr];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= 32'd0;
            wordsLeft <= 32'd0;
            beatsLeft <= 8'd0;
            started   <= 1'b0;
            timer     <= '0;
            CmdStatus <= 2'd0;
            RdReq     <= 1'b0;
            RdAddr    <= 32'd0;
            RdLen     <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (CmdStart) begin
                        if (CmdLength != 32'd0) begin
                            addr      <= CmdAddr;
                            wordsLeft <= {2'b00, CmdLength[31:2]} + {31'd0, |CmdLength[1:0]};
                            beatsLeft <= 8'd0;
                            started   <= 1'b0;
                            timer     <= timerReload;
                            CmdStatus <= 2'd0;
                            state     <= FETCH;
                        end else begin
                            CmdStatus <= 2'd2;
                            state     <= DONE;
                        end
                    end
                end
                FETCH, DRAIN: begin
                    if (!JpegDecodeIdle) begin
                        started <= 1'b1;
                    end
                    if (activity) begin
                        timer <= timerReload;
                    end else if (timer != '0) begin
                        timer <= timer - 1'b1;
                    end
                    if (ackNow) begin
                        addr      <= addr + {22'd0, RdLen, 2'b00};
                        wordsLeft <= wordsLeft - 32'(RdLen);
                        beatsLeft <= RdLen;
                        RdReq     <= 1'b0;
                    end else if (fifoWrite) begin
                        beatsLeft <= beatsLeft - 8'd1;
                    end
                    if (issue) begin
                        RdReq  <= 1'b1;
                        RdAddr <= addr;
                        RdLen  <= lenNext;
                    end
                    if (completion) begin
                        CmdStatus <= 2'd0;
                        state     <= FLUSH;
                    end else if (timeoutHit) begin
                        CmdStatus <= 2'd1;
                        state     <= FLUSH;
                    end else if (abortHit) begin
                        CmdStatus <= 2'd3;
                        state     <= FLUSH;
                    end else if (state == FETCH && wordsLeft == 32'd0 && beatsLeft == 8'd0 && !RdReq) begin
                        state <= DRAIN;
                    end
                end
                FLUSH: begin
                    // A request acked as it is being dropped still delivers its beats.
                    RdReq <= 1'b0;
                    if (ackNow) begin
                        beatsLeft <= RdLen;
                    end else if (RdDataValid && beatsLeft != 8'd0) begin
                        beatsLeft <= beatsLeft - 8'd1;
                    end
                    if (fifoClear) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            PixelCount <= 32'd0;
        end else if (state == IDLE && CmdStart) begin
            PixelCount <= 32'd0;
        end else if (pixelAccept) begin
            PixelCount <= PixelCount + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || fifoClear) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (fifoWrite) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (fifoPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            count <= count + (AW+1)'(fifoWrite) - (AW+1)'(fifoPop);
        end
    end

    always_ff @(posedge clk) begin
        if (fifoWrite) begin
            fifoMem[wrPtr] <= RdData;
        end
    end

endmodule
